// File: rtl/soc_system_button_poller_pkg.sv
// Shared types, default parameters and width helpers for the button poller.
package soc_system_button_poller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } poll_state_t;

  localparam int unsigned DEF_WIDTH        = 3;
  localparam int unsigned DEF_POLL_DIV     = 50000;
  localparam int unsigned DEF_DEBOUNCE     = 4;
  localparam int unsigned DEF_READ_LATENCY = 1;
  localparam int unsigned DEF_DATA_ADDR    = 0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to hold any value 0..v, never less than one.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v < 1) ? 1 : clog2(v + 1);
  endfunction

endpackage

// File: rtl/soc_system_button_debounce.sv
// Debounce of sampled button vector with press/release event pulses.
module soc_system_button_debounce
  import soc_system_button_poller_pkg::*;
#(
  parameter int unsigned     WIDTH       = DEF_WIDTH,
  parameter int unsigned     DEBOUNCE    = DEF_DEBOUNCE,
  parameter logic [WIDTH-1:0] RESET_LEVEL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] buttons_stable,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] released
);

  localparam int unsigned   CW      = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [WIDTH-1:0] candidate;
  logic [CW-1:0]    match_cnt;
  logic [CW-1:0]    match_nxt;
  logic             accept;

  always_comb begin
    match_nxt = match_cnt;
    if (sample != candidate) begin
      match_nxt = CW'(1);
    end else if (match_cnt != CNT_MAX) begin
      match_nxt = match_cnt + 1'b1;
    end
    accept = sample_en && (match_nxt == CNT_MAX) && (sample != buttons_stable);
  end

  // Match counter starts saturated so the reset level counts as already settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candidate      <= RESET_LEVEL;
      match_cnt      <= CNT_MAX;
      buttons_stable <= RESET_LEVEL;
      press          <= '0;
      released       <= '0;
    end else begin
      press    <= '0;
      released <= '0;
      if (sample_en) begin
        candidate <= sample;
        match_cnt <= match_nxt;
      end
      if (accept) begin
        buttons_stable <= sample;
        press          <= buttons_stable & ~sample;
        released       <= ~buttons_stable & sample;
      end
    end
  end

endmodule

// File: rtl/soc_system_button_poller.sv
// Avalon-MM read master polling a button PIO, debouncing and emitting events.
module soc_system_button_poller
  import soc_system_button_poller_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter int unsigned      POLL_DIV     = DEF_POLL_DIV,
  parameter int unsigned      DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned      READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned      DATA_ADDR    = DEF_DATA_ADDR,
  parameter logic [WIDTH-1:0] RESET_LEVEL  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] buttons_stable,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] released,
  output logic             sample_valid,
  output logic             overrun
);

  localparam int unsigned   TW           = clog2(POLL_DIV);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_DIV - 1);
  localparam int unsigned   LW           = cnt_width(READ_LATENCY);
  localparam logic [LW-1:0] LAT_LAST     = LW'(READ_LATENCY - 1);

  poll_state_t   state;
  poll_state_t   state_nxt;
  logic [TW-1:0] timer;
  logic [LW-1:0] lat_cnt;
  logic          tick;
  logic          sample_en;

  assign avm_address = 2'(DATA_ADDR);
  assign tick        = enable && (timer == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= TIMER_RELOAD;
    end else if (!enable || (timer == '0)) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // enable is deliberately ignored once a read is issued; reads always complete.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (tick) state_nxt = ST_REQ;
      ST_REQ:  if (!avm_waitrequest) state_nxt = ST_WAIT;
      ST_WAIT: if (lat_cnt == LAT_LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    avm_read  = (state == ST_REQ);
    sample_en = (state == ST_WAIT) && (lat_cnt == LAT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (state == ST_REQ) begin
      lat_cnt <= '0;
    end else if (state == ST_WAIT) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun      <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_en;
      if (tick && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_readdata_hi;
      assign unused_readdata_hi = ^avm_readdata[31:WIDTH];
    end
  endgenerate

  soc_system_button_debounce #(
    .WIDTH       (WIDTH),
    .DEBOUNCE    (DEBOUNCE),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_debounce (
    .clk            (clk),
    .reset          (reset),
    .sample_en      (sample_en),
    .sample         (avm_readdata[WIDTH-1:0]),
    .buttons_stable (buttons_stable),
    .press          (press),
    .released       (released)
  );

endmodule

// File: tb/tb_soc_system_button_poller.sv
// Self-checking bench: slave model with scoreboard of expected debounce results.
module tb_soc_system_button_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [2:0]  buttons_stable;
  logic [2:0]  press;
  logic [2:0]  released;
  logic        sample_valid;
  logic        overrun;

  always #5 clk = ~clk;

  soc_system_button_poller #(
    .WIDTH        (3),
    .POLL_DIV     (8),
    .DEBOUNCE     (3),
    .READ_LATENCY (1),
    .DATA_ADDR    (0),
    .RESET_LEVEL  (3'b111)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .buttons_stable  (buttons_stable),
    .press           (press),
    .released        (released),
    .sample_valid    (sample_valid),
    .overrun         (overrun)
  );

  typedef struct {
    int unsigned cyc;
    logic [2:0]  st;
    logic [2:0]  pr;
    logic [2:0]  rl;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned n_accepts = 0;
  int unsigned rise_count = 0;
  int unsigned last_rise_cyc = 0;
  int unsigned press_cnt = 0;
  int unsigned rel_cnt = 0;
  logic        prev_read = 1'b0;
  logic [2:0]  level = 3'b111;
  logic [2:0]  acc_v;
  logic [31:0] rd_tmp;
  logic [2:0]  h0 = 3'b111, h1 = 3'b111, h2 = 3'b111, m_stable = 3'b111;
  logic [2:0]  epr, erl;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: data valid only during the cycle after accept, complemented otherwise.
  initial begin
    avm_readdata = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (!reset && avm_read && !avm_waitrequest) begin
        acc_v = level;
        n_accepts++;
        h2 = h1; h1 = h0; h0 = acc_v;
        if (h0 == h1 && h1 == h2 && h0 != m_stable) begin
          epr = m_stable & ~h0;
          erl = ~m_stable & h0;
          m_stable = h0;
        end else begin
          epr = 3'b000;
          erl = 3'b000;
        end
        sb.push_back('{cyc + 2, m_stable, epr, erl});
        @(posedge clk); #1;
        rd_tmp = $urandom(); rd_tmp[2:0] = acc_v; avm_readdata = rd_tmp;
        @(posedge clk); #1;
        rd_tmp = $urandom(); rd_tmp[2:0] = ~acc_v; avm_readdata = rd_tmp;
      end
    end
  end

  always @(negedge clk) begin
    if (avm_read && !prev_read) begin
      rise_count++;
      last_rise_cyc = cyc;
    end
    prev_read = avm_read;
    checks++;
    if (sample_valid) begin
      if (press != 3'b000) press_cnt++;
      if (released != 3'b000) rel_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got sample_valid=1 want no sample pending");
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL sample_cycle got %0d want %0d", cyc, mon_e.cyc);
        end
        checks++;
        if ({buttons_stable, press, released} !== {mon_e.st, mon_e.pr, mon_e.rl}) begin
          errors++;
          $display("FAIL sample_result got st=%b pr=%b rl=%b want st=%b pr=%b rl=%b",
                   buttons_stable, press, released, mon_e.st, mon_e.pr, mon_e.rl);
        end
      end
    end else if (press !== 3'b000 || released !== 3'b000) begin
      errors++;
      $display("FAIL pulse_outside_sample got pr=%b rl=%b want 000", press, released);
    end
  end

  task automatic wait_rises(input int unsigned n);
    int unsigned target;
    bit ok;
    target = rise_count + n;
    ok = 1'b0;
    for (int i = 0; i < 40 * int'(n); i++) begin
      @(posedge clk); #1;
      if (rise_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_timeout got rises=%0d want %0d", rise_count, target);
    end
  endtask

  task automatic poll(input logic [2:0] v);
    int unsigned target;
    bit ok;
    level = v;
    target = n_accepts + 1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (n_accepts >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL poll_timeout got accepts=%0d want %0d", n_accepts, target);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic check_stable(input string name, input logic [2:0] want);
    checks++;
    if (buttons_stable !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, buttons_stable, want);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({avm_read, avm_address, sample_valid, overrun} !== 5'b0_00_0_0) begin
      errors++;
      $display("FAIL reset_ctrl got rd=%b addr=%0d sv=%b ov=%b want 0 0 0 0",
               avm_read, avm_address, sample_valid, overrun);
    end
    checks++;
    if ({buttons_stable, press, released} !== 9'b111_000_000) begin
      errors++;
      $display("FAIL reset_outputs got st=%b pr=%b rl=%b want 111 000 000",
               buttons_stable, press, released);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_steady();
    int unsigned c0;
    level = 3'b111;
    wait_rises(1);
    c0 = last_rise_cyc;
    for (int k = 0; k < 2; k++) begin
      wait_rises(1);
      checks++;
      if (last_rise_cyc - c0 != 8) begin
        errors++;
        $display("FAIL poll_period got %0d want 8", last_rise_cyc - c0);
      end
      c0 = last_rise_cyc;
      checks++;
      if (avm_address !== 2'd0) begin
        errors++;
        $display("FAIL address got %0d want 0", avm_address);
      end
    end
    drain();
    checks++;
    if (press_cnt != 0 || rel_cnt != 0) begin
      errors++;
      $display("FAIL steady_events got pr=%0d rl=%0d want 0 0", press_cnt, rel_cnt);
    end
    check_stable("steady_stable", 3'b111);
  endtask

  task automatic test_press();
    press_cnt = 0;
    poll(3'b110);
    poll(3'b110);
    drain();
    check_stable("press_before_third", 3'b111);
    poll(3'b110);
    drain();
    check_stable("press_stable", 3'b110);
    checks++;
    if (press_cnt != 1) begin
      errors++;
      $display("FAIL press_count got %0d want 1", press_cnt);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] seq [5];
    seq = '{3'b110, 3'b111, 3'b110, 3'b110, 3'b110};
    rel_cnt = 0;
    for (int k = 0; k < 3; k++) poll(3'b111);
    drain();
    check_stable("release_stable", 3'b111);
    checks++;
    if (rel_cnt != 1) begin
      errors++;
      $display("FAIL release_count got %0d want 1", rel_cnt);
    end
    press_cnt = 0;
    for (int k = 0; k < 4; k++) poll(seq[k]);
    drain();
    check_stable("bounce_no_accept", 3'b111);
    poll(seq[4]);
    drain();
    check_stable("bounce_stable", 3'b110);
    checks++;
    if (press_cnt != 1) begin
      errors++;
      $display("FAIL bounce_press_count got %0d want 1", press_cnt);
    end
    rel_cnt = 0;
    for (int k = 0; k < 3; k++) poll(3'b111);
    drain();
    checks++;
    if (rel_cnt != 1) begin
      errors++;
      $display("FAIL bounce_release_count got %0d want 1", rel_cnt);
    end
  endtask

  task automatic test_waitreq();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got %b want 0", overrun);
    end
    level = 3'b101;
    @(posedge clk); #1;
    avm_waitrequest = 1'b1;
    wait_rises(1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 2'd0) begin
        errors++;
        $display("FAIL stall_hold got rd=%b addr=%0d want 1 0", avm_read, avm_address);
      end
    end
    @(posedge clk); #1;
    avm_waitrequest = 1'b0;
    drain();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun got %b want 1", overrun);
    end
  endtask

  task automatic test_enable();
    int unsigned rc;
    int unsigned e;
    level = 3'b111;
    wait_rises(1);
    enable = 1'b0;
    drain();
    rc = rise_count;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (rise_count != rc) begin
      errors++;
      $display("FAIL disabled_reads got %0d want %0d", rise_count, rc);
    end
    enable = 1'b1;
    e = cyc;
    wait_rises(1);
    checks++;
    if (last_rise_cyc != e + 8) begin
      errors++;
      $display("FAIL reenable_delay got %0d want %0d", last_rise_cyc - e, 8);
    end
    drain();
  endtask

  task automatic test_reset_midtxn();
    bit seen;
    for (int k = 0; k < 3; k++) poll(3'b011);
    drain();
    check_stable("pre_reset_stable", 3'b011);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (avm_read) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_read_timeout got no read want read");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({avm_read, overrun, sample_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async got rd=%b ov=%b sv=%b want 0 0 0", avm_read, overrun, sample_valid);
    end
    check_stable("reset_async_stable", 3'b111);
    sb.delete();
    h0 = 3'b111; h1 = 3'b111; h2 = 3'b111; m_stable = 3'b111;
    level = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    poll(3'b111);
    drain();
    check_stable("post_reset_stable", 3'b111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_steady();
    test_press();
    test_bounce();
    test_waitreq();
    test_enable();
    test_reset_midtxn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
